// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display path.
// Helpers work on fixed maximum widths so any parametrisation can call them.
package display_pkg;

   localparam int unsigned NIBBLE_W   = 4;
   localparam int unsigned MAX_DIGITS = 32;
   localparam int unsigned MAX_NIB_W  = 32;
   localparam int unsigned MAX_DATA_W = 256;

   function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
      return MAX_DIGITS'(1) << idx;
   endfunction

   // Nibble idx of a packed word, zero-extended to MAX_NIB_W bits.
   function automatic logic [MAX_NIB_W-1:0] digit_slice(input logic [MAX_DATA_W-1:0] data,
                                                        input int unsigned idx,
                                                        input int unsigned width);
      logic [MAX_DATA_W-1:0] shifted;
      shifted = data >> (idx * width);
      return shifted[MAX_NIB_W-1:0] & ((MAX_NIB_W'(1) << width) - MAX_NIB_W'(1));
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescaler: tick is high for one cycle out of every PRESCALE.
module scan_prescaler #(
   parameter int unsigned PRESCALE = 65536
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CntW-1:0] pcnt_q, pcnt_d;

   assign tick = (pcnt_q == CntW'(PRESCALE - 1));

   always_comb begin
      pcnt_d = tick ? '0 : pcnt_q + CntW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/digit_scan_mux.sv
// Self-scanning digit multiplexer: latches data_in once per frame and steps a
// one-hot select and nibble through the digits with enable and leading-zero blanking.
module digit_scan_mux #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned NIBBLE_W   = display_pkg::NIBBLE_W,
   parameter int unsigned PRESCALE   = 65536
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_DIGITS*NIBBLE_W-1:0]  data_in,
   input  logic [NUM_DIGITS-1:0]           dig_en,
   input  logic                            lzb_en,
   output logic [NUM_DIGITS-1:0]           sel,
   output logic [NIBBLE_W-1:0]             H,
   output logic                            blank,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
   output logic                            frame_start
);

   import display_pkg::*;

   localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
   localparam int unsigned DataW = NUM_DIGITS * NIBBLE_W;

   logic                  tick;
   logic                  wrap;
   logic [IdxW-1:0]       idx_q, idx_next;
   logic [DataW-1:0]      shadow_q, shadow_next;
   logic [MAX_DATA_W-1:0] shadow_ext;
   logic                  upper_zero;
   logic                  blank_next;
   logic [NIBBLE_W-1:0]   nib_next;
   logic [NUM_DIGITS-1:0] sel_q;
   logic [NIBBLE_W-1:0]   h_q;
   logic                  blank_q;
   logic                  fs_q;

   scan_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   // Everything is evaluated for the digit about to be shown; on the wrap edge
   // the shadow is being reloaded, so the fresh data_in is used directly.
   always_comb begin
      wrap        = tick && (idx_q == IdxW'(NUM_DIGITS - 1));
      idx_next    = wrap ? '0 : idx_q + IdxW'(1);
      shadow_next = wrap ? data_in : shadow_q;
      shadow_ext  = MAX_DATA_W'(shadow_next);

      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((IdxW'(i) >= idx_next) && (digit_slice(shadow_ext, i, NIBBLE_W) != '0)) begin
            upper_zero = 1'b0;
         end
      end

      nib_next   = NIBBLE_W'(digit_slice(shadow_ext, 32'(idx_next), NIBBLE_W));
      blank_next = !dig_en[idx_next] || (lzb_en && (idx_next != '0) && upper_zero);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         shadow_q <= '0;
         sel_q    <= NUM_DIGITS'(1);
         h_q      <= '0;
         blank_q  <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         fs_q <= wrap;
         if (tick) begin
            idx_q    <= idx_next;
            shadow_q <= shadow_next;
            blank_q  <= blank_next;
            sel_q    <= blank_next ? '0 : NUM_DIGITS'(onehot(32'(idx_next)));
            h_q      <= blank_next ? '0 : nib_next;
         end
      end
   end

   assign sel         = sel_q;
   assign H           = h_q;
   assign blank       = blank_q;
   assign digit_idx   = idx_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux: directed scenarios plus random traffic, checked each
// cycle against a time-based model of the scan and a few literal expectations.
module tb_digit_scan_mux;

   localparam int N = 4;
   localparam int W = 4;
   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic [3:0]  dig_en;
   logic        lzb_en;
   logic [3:0]  sel;
   logic [3:0]  H;
   logic        blank;
   logic [1:0]  digit_idx;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int phase  = 0;

   // Model state: cycles since reset release and the frame's latched word.
   int          c;
   logic [15:0] m_shadow;
   int          e_sel, e_h, e_blank, e_idx, e_fs;

   always #5 clk = ~clk;

   digit_scan_mux #(
      .NUM_DIGITS(N),
      .NIBBLE_W  (W),
      .PRESCALE  (P)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .dig_en     (dig_en),
      .lzb_en     (lzb_en),
      .sel        (sel),
      .H          (H),
      .blank      (blank),
      .digit_idx  (digit_idx),
      .frame_start(frame_start)
   );

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic lit(input string tag, input int es, input int eh, input int eb,
                      input int eidx, input int efs);
      chk({tag, "_sel"}, int'(sel), es);
      chk({tag, "_H"}, int'(H), eh);
      chk({tag, "_blank"}, int'(blank), eb);
      chk({tag, "_idx"}, int'(digit_idx), eidx);
      chk({tag, "_fs"}, int'(frame_start), efs);
   endtask

   always @(posedge clk or negedge rst_n) begin
      int   k;
      int   nib;
      logic blk;
      if (!rst_n) begin
         c        = 0;
         m_shadow = '0;
         e_sel    = 1;
         e_h      = 0;
         e_blank  = 0;
         e_idx    = 0;
         e_fs     = 0;
      end else begin
         c++;
         e_fs = 0;
         if (c % P == 0) begin
            k = (c / P) % N;
            if (k == 0) m_shadow = data_in;
            nib     = int'((m_shadow >> (k * W)) & 16'hF);
            blk     = !dig_en[k] || (lzb_en && (k != 0) && ((m_shadow >> (k * W)) == 16'h0));
            e_idx   = k;
            e_blank = int'(blk);
            e_sel   = blk ? 0 : (1 << k);
            e_h     = blk ? 0 : nib;
            e_fs    = (k == 0) ? 1 : 0;
         end
      end
      #1;
      chk("sel", int'(sel), e_sel);
      chk("H", int'(H), e_h);
      chk("blank", int'(blank), e_blank);
      chk("digit_idx", int'(digit_idx), e_idx);
      chk("frame_start", int'(frame_start), e_fs);
      if (!rst_n) begin
         if (phase == 6) lit("rst_mid", 1, 0, 0, 0, 0);
      end else begin
         case (phase)
            1: case (c)
                  2:  lit("p1_c2", 1, 0, 0, 0, 0);
                  4:  lit("p1_c4", 2, 0, 0, 1, 0);
                  8:  lit("p1_c8", 4, 0, 0, 2, 0);
                  12: lit("p1_c12", 8, 0, 0, 3, 0);
                  16: lit("p1_c16", 1, 4, 0, 0, 1);
                  17: lit("p1_c17", 1, 4, 0, 0, 0);
                  20: lit("p1_c20", 2, 3, 0, 1, 0);
                  24: lit("p1_c24", 4, 2, 0, 2, 0);
                  28: lit("p1_c28", 8, 1, 0, 3, 0);
                  default: ;
               endcase
            2: case (c)
                  16: lit("p2_c16", 1, 0, 0, 0, 1);
                  20: lit("p2_c20", 2, 5, 0, 1, 0);
                  24: lit("p2_c24", 0, 0, 1, 2, 0);
                  28: lit("p2_c28", 0, 0, 1, 3, 0);
                  default: ;
               endcase
            3: case (c)
                  16: lit("p3_c16", 1, 0, 0, 0, 1);
                  20: lit("p3_c20", 0, 0, 1, 1, 0);
                  default: ;
               endcase
            4: case (c)
                  16: lit("p4_c16", 0, 0, 1, 0, 1);
                  20: lit("p4_c20", 2, 12, 0, 1, 0);
                  24: lit("p4_c24", 0, 0, 1, 2, 0);
                  28: lit("p4_c28", 8, 10, 0, 3, 0);
                  default: ;
               endcase
            5: case (c)
                  28: lit("p5_c28", 8, 1, 0, 3, 0);
                  32: lit("p5_c32", 1, 2, 0, 0, 1);
                  default: ;
               endcase
            6: case (c)
                  3: lit("p6_c3", 1, 0, 0, 0, 0);
                  4: lit("p6_c4", 2, 0, 0, 1, 0);
                  default: ;
               endcase
            default: ;
         endcase
      end
   end

   task automatic scen(input int ph, input logic [15:0] d, input logic [3:0] en,
                       input logic lz, input int ncyc);
      @(negedge clk);
      rst_n   = 1'b0;
      data_in = d;
      dig_en  = en;
      lzb_en  = lz;
      @(negedge clk);
      phase = ph;
      rst_n = 1'b1;
      repeat (ncyc) @(posedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      data_in = '0;
      dig_en  = 4'hF;
      lzb_en  = 1'b0;
      repeat (2) @(posedge clk);

      scen(1, 16'h1234, 4'hF, 1'b0, 36);
      scen(2, 16'h0050, 4'hF, 1'b1, 36);
      scen(3, 16'h0000, 4'hF, 1'b1, 36);
      scen(4, 16'hABCD, 4'b1010, 1'b0, 36);

      // Change the word while digit 2 is on screen; it must wait for the wrap.
      scen(5, 16'h1111, 4'hF, 1'b0, 25);
      @(negedge clk);
      data_in = 16'h2222;
      repeat (12) @(posedge clk);

      // Reset in slot 3 with the prescaler at 2.
      scen(7, 16'h1234, 4'hF, 1'b0, 14);
      @(negedge clk);
      phase = 6;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);

      @(negedge clk);
      phase = 8;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            for (int j = 0; j < N; j++) begin
               data_in[j*W +: W] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
         end
         if ($urandom_range(0, 15) == 0) dig_en = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) lzb_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      repeat (3) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
